ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for the EX stage; implements DIV and DIVU.
- Produces remainder (HI) and quotient (LO). EX forwards these as ex_hi/ex_lo with ex_hilo_en into the EX/MEM pipeline register.
- While a divide is in flight, EX raises a pipeline stall built from busy/ready.
- Runs 32 iterations, or a 1-cycle short path for a zero divisor.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; held high by EX until ready is seen
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- opdata1  input  WIDTH  dividend; sampled with start
- opdata2  input  WIDTH  divisor; sampled with start
- annul  input  1  abort in-flight divide (branch/flush)
- busy  output  1  divide in progress (ON or BY_ZERO state)
- ready  output  1  result valid
- result_hi  output  WIDTH  remainder
- result_lo  output  WIDTH  quotient

Behaviour:
- Reset (rst=1 at a clock edge): state=FREE, counter=0, ready=0, busy=0, result_hi/result_lo=0. Reset wins over every other input, including mid-divide.
- States: FREE, BY_ZERO, ON, END. busy = (state==ON || state==BY_ZERO).
- FREE:
  - start=1 and annul=0 are sampled at the edge.
  - If opdata2==0, go to BY_ZERO.
  - Otherwise latch the operands and go to ON, with counter=0.
  - If signed_div=1, latch |opdata1| and |opdata2| and record both sign bits.
  - |0x80000000| = 0x80000000 (unsigned interpretation).
  - start with annul=1 is ignored.
- BY_ZERO: after 1 cycle, go to END with quotient=0, remainder=0.
- ON, per cycle:
  - Working register is 2*WIDTH+1 bits, initialised {0, dividend, 0}.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and shift in 1; else shift in 0.
  - counter++. When counter reaches WIDTH, go to END.
- Sign fix-up, applied on entering END when signed_div was 1:
  - Quotient is negated iff the operand signs differ.
  - Remainder is negated iff the dividend was negative.
- END:
  - ready=1; result_hi/result_lo hold the final values.
  - Stay in END while start=1. When start=0, go to FREE next edge, with ready=0 and results cleared to 0.
- annul=1 in BY_ZERO, ON or END: go to FREE next edge, ready=0, results 0, no partial result exposed.
- Latency:
  - Non-zero divisor: ready is first high after the 33rd rising edge, counting the edge that samples start as edge 1.
  - Zero divisor: ready is first high after edge 2.
- Operand inputs are ignored outside FREE; changing them mid-divide has no effect.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Outputs are registered; no combinational path from inputs to ready/result.

Decomposition:
- Shared defines file gains:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits)
  - DivStart/DivStop, DivResultReady/DivResultNotReady
  - existing ZeroWord and RstEnable are reused
- No sub-module. Conditional negation is an inline function. A separate abs/negate helper module is not warranted.

Test Plan:
- DIVU 100 / 7, start held → ready after edge 33; result_lo=14, result_hi=2. Drop start → next edge ready=0, results 0.
- DIV 0xFFFFFFF9 (-7) / 2 → result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Divisor 0, any dividend, signed and unsigned → busy for 1 cycle; ready after edge 2; lo=0, hi=0.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- Abort cases:
  - annul pulse at edge 10 of an ON sequence → FREE at edge 11, ready never asserts.
  - New start after that → correct result, 33-edge latency.
  - rst asserted at edge 20 → all outputs 0 at edge 21.
- Operand changes while busy=1 → result matches the originally sampled operands. start=1 with annul=1 in FREE → no state change.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared encodings and control constants for the EX-stage divider.
package ex_div_pkg;
  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_e;
  localparam logic RstEnable = 1'b1;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
endpackage

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider (DIV/DIVU) producing remainder and quotient.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  input  logic             annul,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
  div_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2*WIDTH:0] wr, wr_n, step;
  logic [WIDTH:0] diff;
  logic [WIDTH-1:0] dvs, dvs_n, hi_n, lo_n;
  logic neg_q, neg_r, neg_q_n, neg_r_n, ready_n;
  assign busy = (state == DivOn) || (state == DivByZero);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wr_n = wr;
    dvs_n = dvs;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    ready_n = ready;
    hi_n = result_hi;
    lo_n = result_lo;
    // upper WIDTH+1 bits hold the partial remainder with the next dividend bit
    diff = wr[2*WIDTH:WIDTH] - {1'b0, dvs};
    step = diff[WIDTH] ? {wr[2*WIDTH-1:0], 1'b0} : {diff[WIDTH-1:0], wr[WIDTH-1:0], 1'b1};
    unique case (state)
      DivFree: if (start == DivStart && !annul) begin
        if (opdata2 == '0) state_n = DivByZero;
        else begin
          state_n = DivOn;
          cnt_n = '0;
          wr_n = {{WIDTH{1'b0}}, cneg(opdata1, signed_div & opdata1[WIDTH-1]), 1'b0};
          dvs_n = cneg(opdata2, signed_div & opdata2[WIDTH-1]);
          neg_q_n = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          neg_r_n = signed_div & opdata1[WIDTH-1];
        end
      end
      DivByZero: begin
        state_n = annul ? DivFree : DivEnd;
        ready_n = annul ? DivResultNotReady : DivResultReady;
        hi_n = '0;
        lo_n = '0;
      end
      DivOn: if (annul) begin
        state_n = DivFree;
        ready_n = DivResultNotReady;
        hi_n = '0;
        lo_n = '0;
      end else begin
        wr_n = step;
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n = DivEnd;
          ready_n = DivResultReady;
          lo_n = cneg(step[WIDTH-1:0], neg_q);
          hi_n = cneg(step[2*WIDTH:WIDTH+1], neg_r);
        end
      end
      DivEnd: if (annul || start == DivStop) begin
        state_n = DivFree;
        ready_n = DivResultNotReady;
        hi_n = '0;
        lo_n = '0;
      end
      default: state_n = DivFree;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= DivFree;
      cnt <= '0;
      wr <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ready <= DivResultNotReady;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr <= wr_n;
      dvs <= dvs_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      ready <= ready_n;
      result_hi <= hi_n;
      result_lo <= lo_n;
    end
  end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div with hand-computed quotients/remainders.
module tb_ex_div;
  logic clk = 1'b0;
  logic rst, start, signed_div, annul;
  logic [31:0] opdata1, opdata2;
  logic busy, ready;
  logic [31:0] result_hi, result_lo;
  int passed = 0;
  int total = 0;
  ex_div dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .busy(busy), .ready(ready), .result_hi(result_hi), .result_lo(result_lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat);
    int n;
    signed_div = sd;
    opdata1 = a;
    opdata2 = b;
    start = 1'b1;
    edge1();
    n = 1;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    opdata1 = ~a;
    opdata2 = 32'h0;
    signed_div = ~sd;
    while (!ready && n < 100) begin
      edge1();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " lo"}, 64'(result_lo), 64'(exp_lo));
    chk({tag, " hi"}, 64'(result_hi), 64'(exp_hi));
    edge1();
    chk({tag, " hold ready"}, 64'(ready), 64'd1);
    chk({tag, " hold lo"}, 64'(result_lo), 64'(exp_lo));
    start = 1'b0;
    edge1();
    chk({tag, " drop ready"}, 64'(ready), 64'd0);
    chk({tag, " drop results"}, {result_hi, result_lo}, 64'd0);
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    annul = 1'b0;
    opdata1 = 32'h0;
    opdata2 = 32'h0;
    edge1();
    edge1();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset results", {result_hi, result_lo}, 64'd0);
    rst = 1'b0;
    edge1();
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run_div("div zero", 1'b1, 32'h8765_4321, 32'h0, 32'h0, 32'h0, 2);
    run_div("divu zero", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 2);
    run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 33);
    run_div("divu 1000/1000", 1'b0, 32'd1000, 32'd1000, 32'd1, 32'd0, 33);
    // abort mid-divide: annul raised after edge 10, sampled at edge 11
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (10) edge1();
    chk("pre-annul busy", 64'(busy), 64'd1);
    annul = 1'b1;
    start = 1'b0;
    edge1();
    annul = 1'b0;
    chk("annul busy", 64'(busy), 64'd0);
    chk("annul ready", 64'(ready), 64'd0);
    seen = 0;
    repeat (40) begin
      edge1();
      seen += int'(ready);
    end
    chk("annul no ready", 64'(seen), 64'd0);
    run_div("after annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    // reset mid-divide
    opdata1 = 32'd12345;
    opdata2 = 32'd3;
    start = 1'b1;
    repeat (19) edge1();
    rst = 1'b1;
    start = 1'b0;
    edge1();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst results", {result_hi, result_lo}, 64'd0);
    rst = 1'b0;
    edge1();
    // start with annul in FREE is ignored
    start = 1'b1;
    annul = 1'b1;
    opdata1 = 32'd9;
    opdata2 = 32'd0;
    edge1();
    chk("start+annul busy", 64'(busy), 64'd0);
    edge1();
    chk("start+annul ready", 64'(ready), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    edge1();
    run_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
